// File: rtl/fir_pkg.sv
// Shared state encoding and width helpers for the sequential FIR filter.
package fir_pkg;

  localparam int SAT_MAXW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } fir_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Sign-extends the low in_w bits of v, then clamps to the signed out_w range.
  function automatic logic signed [SAT_MAXW-1:0] sat_trunc(
    input logic signed [SAT_MAXW-1:0] v,
    input int                         in_w,
    input int                         out_w
  );
    logic signed [SAT_MAXW-1:0] ext;
    logic signed [SAT_MAXW-1:0] hi;
    logic signed [SAT_MAXW-1:0] lo;
    ext = (v <<< (SAT_MAXW - in_w)) >>> (SAT_MAXW - in_w);
    hi  = {1'b0, {(SAT_MAXW-1){1'b1}}} >> (SAT_MAXW - out_w);
    lo  = ~hi;
    if (ext > hi) return hi;
    if (ext < lo) return lo;
    return ext;
  endfunction

endpackage

// File: rtl/fir_filter_seq_mac.sv
// Shared signed multiplier feeding an AWL-wide accumulator with clear and enable.
// acc_nxt is the sum the next enabled edge stores, so control can capture it early.
module fir_mac #(
  parameter int WL  = 32,
  parameter int CWL = 16,
  parameter int AWL = 51
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic signed [WL-1:0]  smp,
  input  logic signed [CWL-1:0] coef,
  output logic signed [AWL-1:0] acc_nxt
);

  localparam int PW = WL + CWL;

  logic [PW-1:0]         smp_ext;
  logic [PW-1:0]         coef_ext;
  logic [PW-1:0]         prod;
  logic signed [AWL-1:0] acc_q;
  logic signed [AWL-1:0] acc_d;

  // Operands are sign-extended to the product width, so the low PW bits are the signed product.
  always_comb begin
    smp_ext  = {{(PW-WL){smp[WL-1]}}, smp};
    coef_ext = {{(PW-CWL){coef[CWL-1]}}, coef};
    prod     = smp_ext * coef_ext;
    acc_nxt  = acc_q + {{(AWL-PW){prod[PW-1]}}, prod};
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_filter_seq.sv
// Sequential FIR: one shared multiplier walks the taps, then the scaled, saturated result
// is held behind a valid/ready handshake; coefficients and flush act only while idle.
module fir_filter_seq
  import fir_pkg::*;
#(
  parameter int WL    = 32,
  parameter int CWL   = 16,
  parameter int NTAPS = 8,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WL-1:0]           x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic [WL-1:0]           y_out,
  output logic                    y_valid,
  input  logic                    y_ready,
  input  logic                    coef_wr,
  input  logic [clog2(NTAPS)-1:0] coef_addr,
  input  logic [CWL-1:0]          coef_data,
  input  logic                    flush
);

  localparam int            KW     = clog2(NTAPS);
  localparam int            AWL    = WL + CWL + KW;
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);

  fir_state_e state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [WL-1:0]  d_q [NTAPS];
  logic [WL-1:0]  d_d [NTAPS];
  logic [CWL-1:0] c_q [NTAPS];
  logic [CWL-1:0] c_d [NTAPS];
  logic [WL-1:0]  y_q, y_d;
  logic           y_vld_q, y_vld_d;
  logic           mac_clr;
  logic           mac_en;

  logic signed [AWL-1:0]      acc_nxt;
  logic signed [AWL-1:0]      acc_sh;
  logic signed [SAT_MAXW-1:0] sat_res;
  logic                       sat_unused;

  fir_mac #(
    .WL (WL),
    .CWL(CWL),
    .AWL(AWL)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .smp    (d_q[k_q]),
    .coef   (c_q[k_q]),
    .acc_nxt(acc_nxt)
  );

  // The final product is folded in combinationally so the result lands on the MAC->HOLD edge.
  assign acc_sh     = acc_nxt >>> SHIFT;
  assign sat_res    = sat_trunc(SAT_MAXW'(acc_sh), AWL, WL);
  assign sat_unused = ^sat_res[SAT_MAXW-1:WL];

  assign y_out   = y_q;
  assign y_valid = y_vld_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    c_d     = c_q;
    y_d     = y_q;
    y_vld_d = y_vld_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    x_ready = 1'b0;
    case (state_q)
      IDLE: begin
        x_ready = !flush;
        if (coef_wr && (int'(coef_addr) < NTAPS)) begin
          c_d[coef_addr] = coef_data;
        end
        if (flush) begin
          for (int i = 0; i < NTAPS; i++) d_d[i] = '0;
        end else if (x_valid) begin
          for (int i = NTAPS - 1; i > 0; i--) d_d[i] = d_q[i-1];
          d_d[0]  = x_in;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == K_LAST) begin
          y_d     = sat_res[WL-1:0];
          y_vld_d = 1'b1;
          state_d = HOLD;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      HOLD: begin
        if (y_ready) begin
          y_vld_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      y_q     <= '0;
      y_vld_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        d_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      d_q     <= d_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Directed scoreboard bench: instance a (4 taps, no shift) and instance b (3 taps, shift 2).
module tb_fir_filter_seq;

  localparam int A_N = 4;
  localparam int B_N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_x_in = '0;
  logic       a_x_valid = 1'b0;
  logic       a_x_ready;
  logic [7:0] a_y_out;
  logic       a_y_valid;
  logic       a_y_ready = 1'b1;
  logic       a_coef_wr = 1'b0;
  logic [1:0] a_coef_addr = '0;
  logic [7:0] a_coef_data = '0;
  logic       a_flush = 1'b0;

  logic [7:0] b_x_in = '0;
  logic       b_x_valid = 1'b0;
  logic       b_x_ready;
  logic [7:0] b_y_out;
  logic       b_y_valid;
  logic       b_y_ready = 1'b1;
  logic       b_coef_wr = 1'b0;
  logic [1:0] b_coef_addr = '0;
  logic [7:0] b_coef_data = '0;
  logic       b_flush = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic signed [31:0] q_a[$];
  logic signed [31:0] q_b[$];

  fir_filter_seq #(.WL(8), .CWL(8), .NTAPS(A_N), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .x_in(a_x_in), .x_valid(a_x_valid), .x_ready(a_x_ready),
    .y_out(a_y_out), .y_valid(a_y_valid), .y_ready(a_y_ready), .coef_wr(a_coef_wr),
    .coef_addr(a_coef_addr), .coef_data(a_coef_data), .flush(a_flush)
  );

  fir_filter_seq #(.WL(8), .CWL(8), .NTAPS(B_N), .SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .x_in(b_x_in), .x_valid(b_x_valid), .x_ready(b_x_ready),
    .y_out(b_y_out), .y_valid(b_y_valid), .y_ready(b_y_ready), .coef_wr(b_coef_wr),
    .coef_addr(b_coef_addr), .coef_data(b_coef_data), .flush(b_flush)
  );

  function automatic logic signed [31:0] sx(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic signed [31:0] b1(input logic v);
    return {31'd0, v};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input int addr, input int data);
    a_coef_wr   = 1'b1;
    a_coef_addr = 2'(addr);
    a_coef_data = 8'(data);
    tick();
    a_coef_wr = 1'b0;
  endtask

  task automatic a_load(input int c0, input int c1, input int c2, input int c3);
    a_write(0, c0);
    a_write(1, c1);
    a_write(2, c2);
    a_write(3, c3);
  endtask

  task automatic a_flush_pulse();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
  endtask

  task automatic a_send(input int x, input int exp, input bit wr, input int addr, input int data);
    int n = 0;
    while (!a_x_ready && n < 40) begin
      tick();
      n++;
    end
    chk("a_accept_ready", b1(a_x_ready), 1);
    a_x_valid = 1'b1;
    a_x_in    = 8'(x);
    if (wr) begin
      a_coef_wr   = 1'b1;
      a_coef_addr = 2'(addr);
      a_coef_data = 8'(data);
    end
    tick();
    a_x_valid = 1'b0;
    a_coef_wr = 1'b0;
    q_a.push_back(exp);
  endtask

  // lat0 counts edges already seen since (and including) the accepting edge.
  task automatic a_recv(input string tag, input int lat0);
    int lat = lat0;
    while (!a_y_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, A_N + 1);
    chk({tag, "_y"}, sx(a_y_out), q_a.pop_front());
    if (a_y_ready) tick();
  endtask

  task automatic b_write(input int addr, input int data);
    b_coef_wr   = 1'b1;
    b_coef_addr = 2'(addr);
    b_coef_data = 8'(data);
    tick();
    b_coef_wr = 1'b0;
  endtask

  task automatic b_xfer(input string tag, input int x, input int exp);
    int n = 0;
    int lat = 1;
    while (!b_x_ready && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, b1(b_x_ready), 1);
    b_x_valid = 1'b1;
    b_x_in    = 8'(x);
    tick();
    b_x_valid = 1'b0;
    q_b.push_back(exp);
    while (!b_y_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, B_N + 1);
    chk({tag, "_y"}, sx(b_y_out), q_b.pop_front());
    tick();
  endtask

  initial begin
    int n_vld;
    #12;
    chk("rst_a_x_ready", b1(a_x_ready), 1);
    chk("rst_a_y_valid", b1(a_y_valid), 0);
    chk("rst_a_y_out", sx(a_y_out), 0);
    chk("rst_b_x_ready", b1(b_x_ready), 1);
    chk("rst_b_y_valid", b1(b_y_valid), 0);
    rst_n = 1'b1;
    tick();

    // Instance b: floor-rounding shift and an out-of-range coefficient address.
    b_write(0, 4);
    b_xfer("b_shift4", -5, -5);
    b_write(3, 100);
    b_write(0, 1);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    b_xfer("b_floor", -5, -2);
    b_xfer("b_floor2", 7, 1);

    // Moving sum over four taps.
    a_load(1, 1, 1, 1);
    a_send(0, 0, 0, 0, 0);   a_recv("sum0", 1);
    a_send(-1, -1, 0, 0, 0); a_recv("sum1", 1);
    a_send(-2, -3, 0, 0, 0); a_recv("sum2", 1);
    a_send(3, 0, 0, 0, 0);   a_recv("sum3", 1);
    a_send(4, 4, 0, 0, 0);   a_recv("sum4", 1);

    // Flush beats a simultaneous sample offer.
    a_flush   = 1'b1;
    a_x_valid = 1'b1;
    a_x_in    = 8'd50;
    #1;
    chk("flush_x_ready", b1(a_x_ready), 0);
    tick();
    a_flush   = 1'b0;
    a_x_valid = 1'b0;
    #1;
    chk("flush_not_accepted", b1(a_x_ready), 1);

    // Impulse response reads the coefficients back out in order.
    a_load(3, -2, 5, 7);
    a_send(1, 3, 0, 0, 0);  a_recv("imp0", 1);
    a_send(0, -2, 0, 0, 0); a_recv("imp1", 1);
    a_send(0, 5, 0, 0, 0);  a_recv("imp2", 1);
    a_send(0, 7, 0, 0, 0);  a_recv("imp3", 1);
    a_send(0, 0, 0, 0, 0);  a_recv("imp4", 1);

    // Saturation at both rails.
    a_flush_pulse();
    a_load(127, 127, 127, 127);
    a_send(127, 127, 0, 0, 0);   a_recv("sat_pos", 1);
    a_flush_pulse();
    a_send(-128, -128, 0, 0, 0); a_recv("sat_neg", 1);

    // Back-pressure: result held, waiting sample left alone.
    a_flush_pulse();
    a_load(2, 1, 0, 0);
    a_y_ready = 1'b0;
    a_send(5, 10, 0, 0, 0);
    a_recv("bp_first", 1);
    a_x_valid = 1'b1;
    a_x_in    = 8'd9;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_y_valid", b1(a_y_valid), 1);
      chk("bp_y_out", sx(a_y_out), 10);
      chk("bp_x_ready", b1(a_x_ready), 0);
    end
    a_y_ready = 1'b1;
    tick();
    chk("bp_release_valid", b1(a_y_valid), 0);
    chk("bp_release_ready", b1(a_x_ready), 1);
    a_send(9, 23, 0, 0, 0);
    a_recv("bp_held", 1);

    // Coefficient writes: ignored mid-MAC, applied in IDLE and alongside an accept.
    a_load(1, 0, 0, 1);
    a_flush_pulse();
    a_send(1, 1, 0, 0, 0); a_recv("cw1", 1);
    a_send(2, 2, 0, 0, 0); a_recv("cw2", 1);
    a_send(3, 3, 0, 0, 0); a_recv("cw3", 1);
    a_send(4, 5, 0, 0, 0);
    a_write(3, 10);
    a_recv("cw_mid_ignored", 2);
    a_write(3, 10);
    a_send(5, 25, 0, 0, 0); a_recv("cw_idle", 1);
    a_send(6, 42, 1, 0, 2); a_recv("cw_with_accept", 1);

    // Reset during MAC discards the sample and clears coefficients.
    a_x_valid = 1'b1;
    a_x_in    = 8'd9;
    tick();
    a_x_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x_ready", b1(a_x_ready), 1);
    chk("mid_rst_y_valid", b1(a_y_valid), 0);
    chk("mid_rst_y_out", sx(a_y_out), 0);
    tick();
    tick();
    rst_n = 1'b1;
    n_vld = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_y_valid) n_vld++;
    end
    chk("mid_rst_no_valid", n_vld, 0);
    a_send(9, 0, 0, 0, 0);
    a_recv("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_filter_seq.md
Name: fir_filter_seq

Overview:
- Parametrised successor to the team's fixed-width direct-form FIR `Filter`.
- Computes `y[n] = sum(k=0..NTAPS-1) c[k]*x[n-k]` with one shared multiplier, time-multiplexed over the taps.
- Coefficients are runtime-loadable, the output is scaled and saturated, and valid/ready handshakes sit on both input and output.
- Sits between a sample source and downstream DSP stages in the filter chain.

Parameters:
- WL, 32, sample and output width (signed two's complement)
- CWL, 16, coefficient width (signed)
- NTAPS, 8, number of taps; legal range is 2 to 256
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- AWL, WL+CWL+clog2(NTAPS), accumulator width (derived; must not be overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- x_in  in  WL  input sample
- x_valid  in  1  input sample is valid
- x_ready  out  1  block can accept a sample
- y_out  out  WL  filtered sample
- y_valid  out  1  y_out is valid
- y_ready  in  1  downstream accepts y_out
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  clog2(NTAPS)  tap index to write
- coef_data  in  CWL  coefficient value
- flush  in  1  synchronous clear of the delay line

Behaviour:
- Reset values (rst_n low, asynchronous):
  - state is IDLE.
  - x_ready=1, y_valid=0, y_out=0.
  - Delay line, all coefficients and the accumulator are 0.
- FSM states: IDLE, MAC, HOLD.
- IDLE:
  - x_ready=1.
  - When x_valid is high at a clock edge:
    - the delay line shifts: d[k] <= d[k-1], d[0] <= x_in;
    - acc <= 0 and tap index k <= 0;
    - next state is MAC.
- MAC:
  - x_ready=0.
  - Each cycle: acc <= acc + d[k]*c[k], k++.
  - Exactly NTAPS cycles, then next state is HOLD.
- Result capture on the MAC->HOLD edge:
  - y_out <= sat_WL(acc_final >>> SHIFT), and y_valid <= 1.
  - The shift is arithmetic, i.e. floor rounding.
  - Saturation clamps to [-2^(WL-1), 2^(WL-1)-1].
- HOLD:
  - y_out and y_valid stay stable until y_ready is high at an edge.
  - On that edge: y_valid <= 0, next state is IDLE.
  - x_ready is 0 throughout HOLD.
- Latency: y_valid rises NTAPS+1 clock edges after the accepting edge.
  - Peak throughput is one sample per NTAPS+2 cycles when y_ready is held high.
- Products and accumulation are sign-extended to AWL. No intermediate overflow is possible at the derived AWL.
- Coefficient writes:
  - coef_wr takes effect only in IDLE: c[coef_addr] <= coef_data.
  - coef_wr in MAC or HOLD is ignored, so coefficients are never changed mid-computation.
  - Writes with coef_addr >= NTAPS are ignored.
- flush:
  - Effective only in IDLE: zeroes the delay line.
  - If flush and an accept occur on the same edge, flush wins. The sample is not accepted, because x_ready is forced to 0 while flush is high.
  - Coefficients are unaffected by flush.
- Simultaneous coef_wr and sample accept in IDLE: the write is applied, and the MAC that follows uses the new value.
- rst_n asserted mid-MAC or mid-HOLD:
  - immediate return to reset values; the partial result is discarded.
  - No output handshake occurs for that sample.
- x_valid in MAC or HOLD is not consumed. The source must hold the sample until x_ready=1.

Decomposition:
- Package `fir_pkg`:
  - clog2 function;
  - state enum/localparams (IDLE, MAC, HOLD);
  - saturating-truncate function parametrised by input and output width.
- Sub-module `fir_mac`:
  - the signed CWLxWL multiplier and AWL-wide accumulator with clear and enable;
  - keeps the datapath separate from the FSM and delay line, so the multiplier can later be pipelined without touching control.

Test Plan:
- NTAPS=4, coefs {1,1,1,1}, SHIFT=0, inputs 0,-1,-2,3,4 -> outputs 0,-1,-3,0,4. Each y_valid occurs exactly 5 edges after its accept.
- Impulse: coefs {3,-2,5,7}, inputs 1,0,0,0,0 -> outputs 3,-2,5,7,0.
- Saturation: WL=8, CWL=8, coefs all 127, input 127 -> y_out=127; after flush, coefs all 127, input -128 -> y_out=-128. SHIFT=2, coefs {4,0,0,0}, input -5 -> -5.
- Back-pressure: hold y_ready=0 for 6 cycles after y_valid -> y_out stable, x_ready=0, and a waiting x_valid is not consumed. Release y_ready -> one transfer, then return to IDLE.
- coef_wr to tap 0 during MAC -> ignored, result unchanged. The same write in IDLE -> the next result uses it. A write with addr=NTAPS -> no effect.
- Drop rst_n during MAC cycle 2 -> outputs reset at once, no y_valid. After release, a fresh sample yields 0 because the coefficients were cleared.
